// File: rtl/aud_dac_feeder.sv
// aud_dac_feeder: sample FIFO between the DSP and the I2S DAC player.
// Presents one sample per LRCK frame; optional AUD_FEEDER_HOLD_EN macro.
//
// Ports:
//   i_bclk, i_rst_n       bit clock, async active-low reset
//   i_en                  play enable
//   i_daclrck             DAC LR clock (synchronous to i_bclk)
//   i_sample/_valid       upstream sample, valid
//   o_sample_ready        feeder accepts a sample this cycle
//   o_dac_data            sample to player, changes only at LRCK rise
//   o_level               FIFO occupancy 0..DEPTH
//   o_playing             high while in RUN
//   o_underrun            1-cycle pulse on a starved frame
//   o_underrun_cnt        saturating underrun count
//
// Config: define AUD_FEEDER_HOLD_EN to repeat the last sample on
// underrun instead of outputting silence.
module aud_dac_feeder #(
   parameter  int DATA_W      = 16,
   parameter  int DEPTH       = 8,
   parameter  int PRIME_LEVEL = 4,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_daclrck,
   input  logic [DATA_W-1:0] i_sample,
   input  logic              i_sample_valid,
   output logic              o_sample_ready,
   output logic [DATA_W-1:0] o_dac_data,
   output logic [ADDR_W:0]   o_level,
   output logic              o_playing,
   output logic              o_underrun,
   output logic [7:0]        o_underrun_cnt
);

   localparam int LVL_W = ADDR_W + 1;
   localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);
   localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   state_t            state;
   logic              lrck_q;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic load_pt;
   logic full;
   logic empty;
   logic push;
   logic start;
   logic pop;
   logic starve;

   // Rising LRCK: the player is in the right half, so a new word
   // loaded now is stable for the whole following left half.
   assign load_pt = !lrck_q && i_daclrck;

   assign full  = (o_level == FULL_LVL);
   assign empty = (o_level == '0);

   // Depends only on registered state; no path from i_sample_valid.
   assign o_sample_ready = (state != IDLE) && !full;
   assign push = i_sample_valid && o_sample_ready;

   assign start = (state == PRIME) && load_pt &&
                  ((o_level >= PRIME_LVL) || full);

   // Pop and starve both look at the registered level, so a push
   // landing on the load point is stored but not seen by this pop.
   assign pop    = i_en && load_pt && !empty &&
                   (start || (state == RUN));
   assign starve = i_en && load_pt && empty && (state == RUN);

   assign o_playing = (state == RUN);

   always_ff @(posedge i_bclk) begin
      if (push) begin
         mem[wr_ptr] <= i_sample;
      end
   end

   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         lrck_q         <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         o_level        <= '0;
         o_dac_data     <= '0;
         o_underrun     <= 1'b0;
         o_underrun_cnt <= '0;
      end else begin
         lrck_q     <= i_daclrck;
         o_underrun <= 1'b0;
         if (!i_en) begin
            // Flush; the underrun count survives until reset.
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_dac_data <= '0;
         end else begin
            unique case (state)
               IDLE:    state <= PRIME;
               PRIME:   if (start) state <= RUN;
               RUN:     state <= RUN;
               default: state <= IDLE;
            endcase
            if (push) begin
               wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
               rd_ptr     <= rd_ptr + ADDR_W'(1);
               o_dac_data <= mem[rd_ptr];
            end else if (starve) begin
               o_underrun <= 1'b1;
               if (o_underrun_cnt != 8'hFF) begin
                  o_underrun_cnt <= o_underrun_cnt + 8'd1;
               end
`ifndef AUD_FEEDER_HOLD_EN
               o_dac_data <= '0;
`endif
            end
            o_level <= o_level + LVL_W'(push) - LVL_W'(pop);
         end
      end
   end

endmodule

// File: tb/tb_aud_dac_feeder.sv
// tb_aud_dac_feeder: directed + randomized bench for aud_dac_feeder.
// Reference model is a sample queue plus play/prime flags.
module tb_aud_dac_feeder;

   localparam int DEPTH = 8;
   localparam int PRIME = 4;
`ifdef AUD_FEEDER_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        bclk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        lrck;
   logic [15:0] sample;
   logic        valid;
   logic        ready;
   logic [15:0] dac;
   logic [3:0]  level;
   logic        playing;
   logic        und;
   logic [7:0]  cnt;

   aud_dac_feeder dut (
      .i_bclk         (bclk),
      .i_rst_n        (rst_n),
      .i_en           (en),
      .i_daclrck      (lrck),
      .i_sample       (sample),
      .i_sample_valid (valid),
      .o_sample_ready (ready),
      .o_dac_data     (dac),
      .o_level        (level),
      .o_playing      (playing),
      .o_underrun     (und),
      .o_underrun_cnt (cnt)
   );

   always #5 bclk = ~bclk;

   int tests = 0;
   int fails = 0;

   // Model state
   logic [15:0] m_q[$];
   bit          m_active;
   bit          m_run;
   bit          m_prev;
   logic [15:0] m_dac;
   bit          m_und;
   int          m_cnt;

   // LRCK auto-toggle
   int half  = 4;
   int phase = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
      chk({tag, ".ready"}, 32'(ready),
          32'(m_active && (m_q.size() < DEPTH)));
      chk({tag, ".play"},  32'(playing), 32'(m_run));
      chk({tag, ".dac"},   32'(dac), 32'(m_dac));
      chk({tag, ".und"},   32'(und), 32'(m_und));
      chk({tag, ".cnt"},   32'(cnt), 32'(m_cnt));
   endtask

   task automatic model_reset();
      m_q.delete();
      m_active = 0;
      m_run    = 0;
      m_prev   = 0;
      m_dac    = '0;
      m_und    = 0;
      m_cnt    = 0;
   endtask

   // Advance the model by one clock from the current inputs, then
   // clock the DUT and compare just after the edge.
   task automatic tick(input string tag);
      bit lp;
      bit acc;
      bit load;
      lp  = lrck && !m_prev;
      acc = valid && m_active && (m_q.size() < DEPTH);
      m_und = 0;
      if (!en) begin
         m_q.delete();
         m_active = 0;
         m_run    = 0;
         m_dac    = '0;
      end else begin
         load = lp && (m_run || (m_active && m_q.size() >= PRIME));
         if (load) begin
            if (m_q.size() > 0) begin
               m_dac = m_q.pop_front();
            end else begin
               m_und = 1;
               if (m_cnt < 255) m_cnt++;
               if (!HOLD) m_dac = '0;
            end
            m_run = 1;
         end
         if (acc) m_q.push_back(sample);
         m_active = 1;
      end
      m_prev = lrck;
      @(posedge bclk);
      #1;
      check_all(tag);
   endtask

   task automatic adv_lrck();
      phase++;
      if (phase >= half) begin
         phase = 0;
         lrck  = ~lrck;
      end
   endtask

   initial begin
      logic [15:0] exp1 [4];
      int saved;
      int guard;
      exp1[0] = 16'h1111;
      exp1[1] = 16'h2222;
      exp1[2] = 16'h3333;
      exp1[3] = 16'h4444;

      rst_n  = 1'b0;
      en     = 1'b0;
      lrck   = 1'b0;
      valid  = 1'b0;
      sample = '0;
      model_reset();
      #2;
      check_all("reset");
      @(posedge bclk);
      #1;
      rst_n = 1'b1;

      // Prime with four samples, then play them out.
      en = 1'b1;
      tick("t1_en");
      for (int i = 0; i < 4; i++) begin
         valid  = 1'b1;
         sample = exp1[i];
         tick("t1_push");
      end
      valid = 1'b0;
      chk("t1_prime_level", 32'(level), 32'd4);
      chk("t1_not_play", 32'(playing), 32'd0);
      for (int i = 0; i < 4; i++) begin
         lrck = 1'b1;
         tick("t1_load");
         chk("t1_play", 32'(playing), 32'd1);
         chk("t1_data", 32'(dac), 32'(exp1[i]));
         lrck = 1'b0;
         tick("t1_low");
         tick("t1_low2");
         chk("t1_hold", 32'(dac), 32'(exp1[i]));
      end

      // Starved frame.
      lrck = 1'b1;
      tick("t3_load");
      chk("t3_und", 32'(und), 32'd1);
      chk("t3_cnt", 32'(cnt), 32'd1);
      chk("t3_dac", 32'(dac), HOLD ? 32'h4444 : 32'h0);
      lrck = 1'b0;
      tick("t3_after");
      chk("t3_pulse", 32'(und), 32'd0);

      // Fill with LRCK frozen; ready must drop after 8.
      en = 1'b0;
      tick("t2_off");
      en = 1'b1;
      tick("t2_on");
      valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         sample = 16'($urandom);
         tick("t2_fill");
      end
      chk("t2_level", 32'(level), 32'd8);
      chk("t2_ready", 32'(ready), 32'd0);
      tick("t2_held");
      valid = 1'b0;

      // Drain to one entry, then push on the load point.
      half  = 2;
      phase = 0;
      guard = 0;
      while (m_q.size() != 1 && guard < 200) begin
         adv_lrck();
         tick("t4_drain");
         guard++;
      end
      chk("t4_drain_to", 32'(m_q.size()), 32'd1);
      guard = 0;
      while (guard < 20) begin
         adv_lrck();
         guard++;
         if (lrck && !m_prev) begin
            valid  = 1'b1;
            sample = 16'hA5A5;
            tick("t4_coinc");
            valid = 1'b0;
            chk("t4_level", 32'(level), 32'd1);
            break;
         end
         tick("t4_wait");
      end
      chk("t4_found", 32'(guard < 20), 32'd1);
      for (int i = 0; i < 8; i++) begin
         adv_lrck();
         tick("t4_out");
      end

      // Disable in RUN with five entries queued.
      valid = 1'b1;
      guard = 0;
      while (m_q.size() != 5 && guard < 20) begin
         sample = 16'($urandom);
         tick("t5_fill");
         guard++;
      end
      valid = 1'b0;
      chk("t5_play", 32'(playing), 32'd1);
      chk("t5_level5", 32'(level), 32'd5);
      saved = m_cnt;
      en = 1'b0;
      tick("t5_off");
      chk("t5_level0", 32'(level), 32'd0);
      chk("t5_dac0", 32'(dac), 32'd0);
      chk("t5_ready0", 32'(ready), 32'd0);
      chk("t5_idle", 32'(playing), 32'd0);
      chk("t5_cnt", 32'(cnt), 32'(saved));

      // Random traffic.
      en = 1'b1;
      for (int s = 0; s < 20; s++) begin
         int pct;
         half = $urandom_range(1, 4);
         pct  = $urandom_range(10, 90);
         for (int c = 0; c < 80; c++) begin
            adv_lrck();
            valid  = ($urandom_range(0, 99) < pct);
            sample = 16'($urandom);
            en     = ($urandom_range(0, 299) != 0);
            tick("rand");
         end
      end
      en    = 1'b1;
      valid = 1'b0;

      // Underrun count saturation.
      half = 1;
      for (int c = 0; c < 600; c++) begin
         adv_lrck();
         tick("sat");
      end
      chk("sat_cnt", 32'(cnt), 32'd255);

      // Asynchronous reset in the middle of a cycle.
      valid = 1'b1;
      sample = 16'h5A5A;
      for (int c = 0; c < 12; c++) begin
         adv_lrck();
         tick("t6_pre");
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_dac", 32'(dac), 32'd0);
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_play", 32'(playing), 32'd0);
      chk("t6_und", 32'(und), 32'd0);
      chk("t6_cnt", 32'(cnt), 32'd0);
      chk("t6_ready", 32'(ready), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
